pkt_tx: RTL and testbench
=========================

PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 Clock and reset SHALL be one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset

REQ-002 Ports SHALL be:
- en  in  1  bit strobe; one serial bit per clk with en=1
- wr_en  in  1  push data_in into the TX buffer
- data_in  in  8  payload byte
- full  out  1  TX buffer full
- empty  out  1  TX buffer empty
- start  in  1  one-cycle pulse that begins a packet
- aa  in  32  access address
- ch_idx  in  `CH_IDX_W  whitening seed
- len  in  8  payload byte count, sampled at start
- busy  out  1  packet in progress
- done  out  1  sticky; last bit sent
- underrun  out  1  sticky; buffer empty when a byte was needed
- tx  out  1  serial data
- tx_valid  out  1  tx carries a packet bit

REQ-003 Parameter: none; TX buffer depth SHALL be TX_BUF_DEPTH=16, from the shared header.

Function
REQ-004 Buffer SHALL be a 16x8 FIFO inside the block.
- A write while full SHALL be dropped.
- A simultaneous push and pop SHALL both occur.
- full and empty SHALL be registered.

REQ-005 FSM states SHALL be IDLE, PRE, AA, PDU, CRC and END.

REQ-006 start in IDLE SHALL latch aa, ch_idx and len, and enter PRE on the next cycle; busy SHALL be 1 from that cycle. start outside IDLE SHALL be ignored.

REQ-007 PRE SHALL send 8 bits, LSB first, of aa[0] ? 8'h55 : 8'hAA.

REQ-008 AA SHALL send aa[31:0], LSB first.

REQ-009 PDU SHALL send len bytes, each LSB first.
- Each byte SHALL be popped from the FIFO one cycle before its first bit is due.
- Bits SHALL be whitened; the whitening LFSR SHALL be seeded from ch_idx on PDU entry.

REQ-010 CRC SHALL compute CRC-24 over the unwhitened PDU bits.
- Polynomial: x^24+x^10+x^9+x^6+x^4+x^3+x+1.
- Initial value: CRC_INIT=24'h555555.
- CRC state SHALL send the 24 bits MSB (bit 23) first, whitened by the continuing LFSR.

REQ-011 Bit stepping:
- The FSM, bit counters, LFSRs and tx SHALL advance only on cycles with en=1.
- en=0 SHALL hold all state.
- tx_valid SHALL be 1 for exactly the PRE-to-last-CRC-bit en-cycles and 0 otherwise.

REQ-012 tx and tx_valid SHALL be registered: the bit appears one clk after the en cycle that selects it.

REQ-013 len=0 SHALL go from AA directly to CRC.

REQ-014 After the last bit, the FSM SHALL enter END: tx_valid=0 and done=1. It SHALL return to IDLE the next cycle, with busy=0.

REQ-015 If the FIFO is empty when a PDU byte must be popped:
- underrun SHALL be set.
- tx_valid SHALL drop on the next clk.
- The FSM SHALL go to IDLE; done SHALL stay 0.

REQ-016 done and underrun SHALL clear on an accepted start.

Reset
REQ-017 rst SHALL force:
- state IDLE
- FIFO emptied: empty=1, full=0
- tx=0, tx_valid=0, busy=0, done=0, underrun=0
- LFSRs cleared

REQ-018 rst mid-packet SHALL abort within one clk, with no further tx_valid.

Configuration
REQ-019 Macro TX_CRC_EN:
- Defined: the CRC state and engine SHALL be present as in REQ-010.
- Undefined: the CRC engine SHALL be omitted, and PDU (or AA when len=0) SHALL go directly to END.

Structure
REQ-020 The shared header SHALL hold:
- `CH_IDX_W, TX_BUF_DEPTH and CRC_INIT
- the CRC polynomial constant
- the FSM state encodings

REQ-021 The sub-module byte_p2s SHALL perform byte-to-serial LSB-first shifting with a load/shift enable. The whitening and crc blocks SHALL be reused as instances.

Verification
REQ-022 Bench scenarios:
- aa=32'h8E89BED6, ch_idx=37, len=2, bytes 8'h02,8'h00, en=1 always -> preamble 0xAA LSB-first; aa bits; whitened PDU. The stream SHALL be accepted by the team's rx with aa_found=1, crc_valid=1 and FIFO readback 02,00.
- Same packet with en toggling 1,0,1,0 -> identical bit sequence; tx_valid high for 2x(8+32+16+24) clks total span.
- aa[0]=1 -> first 8 bits 1,0,1,0,1,0,1,0.
- len=3 with only 2 bytes written -> underrun=1 and tx_valid falls after the 56th bit (8+32+16); done=0.
- 17 writes into an empty buffer -> full=1 after 16 writes; the 17th is dropped; 16 pops return bytes in write order.
- rst asserted at bit 20 of AA -> next clk tx_valid=0, busy=0, empty=1; a fresh start then transmits normally.

Source files
------------

// File: rtl/pkt_tx_pkg.sv
// Shared header for pkt_tx: channel-index width, buffer depth, CRC constants and FSM encodings.
// The CRC stage is built only when TX_CRC_EN is defined.
`ifndef CH_IDX_W
`define CH_IDX_W 6
`endif

package pkt_tx_pkg;
  localparam int TX_BUF_DEPTH = 16;
  localparam int TX_PTR_W     = $clog2(TX_BUF_DEPTH);
  localparam int TX_CNT_W     = TX_PTR_W + 1;
  localparam logic [23:0] CRC_INIT = 24'h555555;
  // x^24 implied; taps x^10+x^9+x^6+x^4+x^3+x+1
  localparam logic [23:0] CRC_POLY = 24'h00065B;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_AA   = 3'd2,
    S_PDU  = 3'd3,
    S_CRC  = 3'd4,
    S_END  = 3'd5
  } tx_state_e;

  function automatic logic [7:0] preamble(input logic aa0);
    return aa0 ? 8'h55 : 8'hAA;
  endfunction
endpackage

// File: rtl/pkt_tx_bitops.sv
// Bit-level helpers for pkt_tx: byte serializer, 7-bit whitening LFSR and CRC-24 engine.
// Each advances only when its step/shift input is high.
module byte_p2s (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       dout
);
  logic [7:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = din;
    else if (shift) sr_d = {1'b0, sr_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign dout = sr_q[0];
endmodule

module pkt_tx_whiten (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_ld,
  input  logic                 step,
  input  logic [`CH_IDX_W-1:0] ch_idx,
  output logic                 wbit
);
  logic [6:0] lfsr_q, lfsr_d;

  // position 0 forced to 1, channel MSB lands in position 1; x^7+x^4+1
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_ld)
      lfsr_d = {ch_idx[0], ch_idx[1], ch_idx[2], ch_idx[3], ch_idx[4], ch_idx[5], 1'b1};
    else if (step)
      lfsr_d = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[6], lfsr_q[2], lfsr_q[1], lfsr_q[0], lfsr_q[6]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign wbit = lfsr_q[6];
endmodule

module pkt_tx_crc24
  import pkt_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        step,
  input  logic        din,
  output logic [23:0] crc
);
  logic [23:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[23] ^ din;
    crc_d = crc_q;
    if (init)      crc_d = CRC_INIT;
    else if (step) crc_d = {crc_q[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/pkt_tx.sv
// Packet serializer: TX FIFO, preamble/AA/whitened PDU (+CRC-24 when TX_CRC_EN) bit stream.
// Every bit step is gated by en; tx/tx_valid are registered.
module pkt_tx
  import pkt_tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [7:0]           data_in,
  output logic                 full,
  output logic                 empty,
  input  logic                 start,
  input  logic [31:0]          aa,
  input  logic [`CH_IDX_W-1:0] ch_idx,
  input  logic [7:0]           len,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output logic                 tx,
  output logic                 tx_valid
);
  logic [7:0]          mem_q [TX_BUF_DEPTH];
  logic [TX_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TX_CNT_W-1:0] cnt_q, cnt_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                push, pop, pop_req;

  assign push = wr_en && !full_q;
  assign pop  = pop_req && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + TX_PTR_W'(push);
    rd_ptr_d = rd_ptr_q + TX_PTR_W'(pop);
    cnt_d    = cnt_q + TX_CNT_W'(push) - TX_CNT_W'(pop);
    full_d   = (cnt_d == TX_CNT_W'(TX_BUF_DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  tx_state_e            state_q;
  logic [4:0]           bit_cnt_q;
  logic [7:0]           byte_cnt_q, len_q;
  logic [31:0]          aa_q;
  logic [`CH_IDX_W-1:0] ch_q;
  logic                 tx_q, tx_valid_q, busy_q, done_q, underrun_q;
  logic [7:0]           pre_bits;
  logic                 p2s_load, p2s_shift, p2s_bit;
  logic                 seed_ld, w_step, wbit;
  logic                 last_byte;

  assign pre_bits  = preamble(aa_q[0]);
  assign last_byte = (byte_cnt_q == len_q - 8'd1);

  // next byte is fetched on the en-step that sends the bit before it
  always_comb begin
    pop_req   = 1'b0;
    p2s_load  = 1'b0;
    p2s_shift = 1'b0;
    seed_ld   = 1'b0;
    w_step    = 1'b0;
    if (en) begin
      case (state_q)
        S_AA: if (bit_cnt_q == 5'd31) begin
          seed_ld  = 1'b1;
          pop_req  = (len_q != 8'd0);
          p2s_load = pop_req;
        end
        S_PDU: begin
          w_step    = 1'b1;
          p2s_shift = 1'b1;
          if (bit_cnt_q == 5'd7 && !last_byte) begin
            pop_req  = 1'b1;
            p2s_load = 1'b1;
          end
        end
        S_CRC:   w_step = 1'b1;
        default: ;
      endcase
    end
  end

  byte_p2s u_p2s (
    .clk(clk), .rst(rst), .load(p2s_load), .shift(p2s_shift),
    .din(mem_q[rd_ptr_q]), .dout(p2s_bit)
  );

  pkt_tx_whiten u_whiten (
    .clk(clk), .rst(rst), .seed_ld(seed_ld), .step(w_step),
    .ch_idx(ch_q), .wbit(wbit)
  );

`ifdef TX_CRC_EN
  logic [23:0] crc_val;
  localparam tx_state_e S_TAIL = S_CRC;

  pkt_tx_crc24 u_crc (
    .clk(clk), .rst(rst), .init(seed_ld), .step(w_step && state_q == S_PDU),
    .din(p2s_bit), .crc(crc_val)
  );
`else
  localparam tx_state_e S_TAIL = S_END;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      aa_q       <= '0;
      ch_q       <= '0;
      tx_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q       <= 1'b0;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          if (start) begin
            aa_q       <= aa;
            ch_q       <= ch_idx;
            len_q      <= len;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_PRE;
          end
        end
        S_PRE: if (en) begin
          tx_q       <= pre_bits[bit_cnt_q[2:0]];
          tx_valid_q <= 1'b1;
          bit_cnt_q  <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_q <= '0;
            state_q   <= S_AA;
          end
        end
        S_AA: if (en) begin
          tx_q       <= aa_q[bit_cnt_q];
          tx_valid_q <= 1'b1;
          bit_cnt_q  <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            if (len_q == 8'd0) state_q <= S_TAIL;
            else if (empty_q) begin
              underrun_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else state_q <= S_PDU;
          end
        end
        S_PDU: if (en) begin
          tx_q       <= p2s_bit ^ wbit;
          tx_valid_q <= 1'b1;
          bit_cnt_q  <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= byte_cnt_q + 8'd1;
            if (last_byte) state_q <= S_TAIL;
            else if (empty_q) begin
              underrun_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end
`ifdef TX_CRC_EN
        S_CRC: if (en) begin
          tx_q       <= crc_val[5'd23 - bit_cnt_q] ^ wbit;
          tx_valid_q <= 1'b1;
          bit_cnt_q  <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_q <= '0;
            state_q   <= S_END;
          end
        end
`endif
        S_END: if (en) begin
          tx_q       <= 1'b0;
          tx_valid_q <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;
  assign tx       = tx_q;
  assign tx_valid = tx_valid_q;
endmodule

// File: tb/tb_pkt_tx.sv
// Directed bench for pkt_tx: table of packet scenarios plus FIFO-full and mid-packet reset sequences.
module tb_pkt_tx;
`ifdef TX_CRC_EN
  localparam int CB = 24;
`else
  localparam int CB = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst, en, wr_en, start;
  logic [7:0]           data_in, len;
  logic [31:0]          aa;
  logic [`CH_IDX_W-1:0] ch_idx;
  logic                 full, empty, busy, done, underrun, tx, tx_valid;

  pkt_tx dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .data_in(data_in),
    .full(full), .empty(empty), .start(start), .aa(aa), .ch_idx(ch_idx),
    .len(len), .busy(busy), .done(done), .underrun(underrun),
    .tx(tx), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  bit   got_q[$];
  bit   exp_q[$];
  int   vclks;
  logic [7:0] pdu [16];

  typedef struct {
    logic [31:0] aa;
    logic [5:0]  ch;
    logic [7:0]  len;
    int          nwr;
    logic [7:0]  b0, b1, b2;
    bit          tog;
    int          exp_bits;
    int          exp_vclks;
    logic [7:0]  exp_pre;
    bit          exp_done;
    bit          exp_und;
  } vec_t;

  localparam int NV = 7;
  vec_t vec [NV];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_stream(input string nm);
    int bad;
    bad = -1;
    if (got_q.size() != exp_q.size()) bad = -2;
    else
      for (int i = 0; i < exp_q.size(); i++)
        if (bad == -1 && got_q[i] != exp_q[i]) bad = i;
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL %s: stream differs (got %0d bits, expected %0d bits, first bad index %0d)",
               nm, got_q.size(), exp_q.size(), bad);
    end
  endtask

  function automatic logic [31:0] pack_bits(input int from, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      if (from + i < got_q.size()) r[i] = got_q[from + i];
    return r;
  endfunction

  // Reference stream: preamble, AA, whitened PDU, optional whitened CRC-24 (MSB first)
  task automatic build_exp(input logic [31:0] a, input logic [5:0] c, input int nb, input bit with_crc);
    bit w [7];
    bit d, o, fb;
    logic [7:0]  pre;
    logic [23:0] crcv;
    exp_q.delete();
    pre = a[0] ? 8'h55 : 8'hAA;
    for (int i = 0; i < 8; i++) exp_q.push_back(pre[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(a[i]);
    w[0] = 1'b1;
    for (int k = 1; k <= 6; k++) w[k] = c[6-k];
    crcv = 24'h555555;
    for (int n = 0; n < nb; n++)
      for (int i = 0; i < 8; i++) begin
        d = pdu[n][i];
        exp_q.push_back(d ^ w[6]);
        o = w[6]; w[6] = w[5]; w[5] = w[4]; w[4] = w[3] ^ o;
        w[3] = w[2]; w[2] = w[1]; w[1] = w[0]; w[0] = o;
        fb = crcv[23] ^ d;
        crcv = crcv << 1;
        if (fb) crcv = crcv ^ 24'h00065B;
      end
    if (with_crc && CB == 24)
      for (int k = 23; k >= 0; k--) begin
        exp_q.push_back(crcv[k] ^ w[6]);
        o = w[6]; w[6] = w[5]; w[5] = w[4]; w[4] = w[3] ^ o;
        w[3] = w[2]; w[2] = w[1]; w[1] = w[0]; w[0] = o;
      end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1; data_in = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic run_pkt(input string nm, input logic [31:0] a, input logic [5:0] c,
                         input logic [7:0] l, input bit tog);
    bit fin;
    got_q.delete(); vclks = 0; fin = 1'b0;
    aa = a; ch_idx = c; len = l; start = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_busy_at_start"}, busy, 1);
    check({nm, "_done_cleared"}, done, 0);
    check({nm, "_underrun_cleared"}, underrun, 0);
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      en = tog ? (cyc % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      if (tx_valid) begin
        vclks++;
        if (en) got_q.push_back(tx);
      end
      if (!busy) fin = 1'b1;
    end
    en = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy still %0d after 600 clks, required 0", nm, busy);
    end
    @(posedge clk); #1;
    check({nm, "_tx_valid_after"}, tx_valid, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; start = 1'b0;
    data_in = '0; len = '0; aa = '0; ch_idx = '0;

    vec[0] = '{32'h8E89BED6, 6'd37, 8'd2, 2, 8'h02, 8'h00, 8'h00, 1'b0, 56+CB, 56+CB,       8'hAA, 1'b1, 1'b0};
    vec[1] = '{32'h8E89BED6, 6'd37, 8'd2, 2, 8'h02, 8'h00, 8'h00, 1'b1, 56+CB, 2*(56+CB),   8'hAA, 1'b1, 1'b0};
    vec[2] = '{32'h12345679, 6'd5,  8'd1, 1, 8'hA5, 8'h00, 8'h00, 1'b0, 48+CB, 48+CB,       8'h55, 1'b1, 1'b0};
    vec[3] = '{32'hFFFF0000, 6'd0,  8'd0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 40+CB, 40+CB,       8'hAA, 1'b1, 1'b0};
    vec[4] = '{32'h8E89BED6, 6'd37, 8'd3, 2, 8'h02, 8'h00, 8'h00, 1'b0, 56,    56,          8'hAA, 1'b0, 1'b1};
    vec[5] = '{32'hC0FFEE01, 6'd12, 8'd2, 0, 8'h00, 8'h00, 8'h00, 1'b0, 40,    40,          8'h55, 1'b0, 1'b1};
    vec[6] = '{32'h5A5A5A5B, 6'd63, 8'd1, 1, 8'h3C, 8'h00, 8'h00, 1'b1, 48+CB, 2*(48+CB),   8'h55, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_tx", tx, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);

    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < 16; i++) pdu[i] = 8'h00;
      pdu[0] = vec[v].b0; pdu[1] = vec[v].b1; pdu[2] = vec[v].b2;
      for (int i = 0; i < vec[v].nwr; i++) push_byte(pdu[i]);
      build_exp(vec[v].aa, vec[v].ch, vec[v].nwr, !vec[v].exp_und);
      run_pkt($sformatf("v%0d", v), vec[v].aa, vec[v].ch, vec[v].len, vec[v].tog);
      check_stream($sformatf("v%0d_stream", v));
      check($sformatf("v%0d_nbits", v), got_q.size(), vec[v].exp_bits);
      check($sformatf("v%0d_valid_clks", v), vclks, vec[v].exp_vclks);
      check($sformatf("v%0d_preamble", v), pack_bits(0, 8), {24'h0, vec[v].exp_pre});
      check($sformatf("v%0d_aa_bits", v), pack_bits(8, 32), vec[v].aa);
      check($sformatf("v%0d_done", v), done, vec[v].exp_done);
      check($sformatf("v%0d_underrun", v), underrun, vec[v].exp_und);
      check($sformatf("v%0d_empty", v), empty, 1);
    end

    // FIFO fill: 16 accepted, 17th dropped, then drained in order by a len=16 packet
    for (int i = 0; i < 16; i++) begin
      pdu[i] = 8'(i * 17 + 3);
      push_byte(pdu[i]);
      if (i == 14) check("fifo_not_full_15", full, 0);
    end
    check("fifo_full_16", full, 1);
    check("fifo_not_empty_16", empty, 0);
    push_byte(8'hEE);
    check("fifo_full_17", full, 1);
    build_exp(32'h8E89BED6, 6'd21, 16, 1'b1);
    run_pkt("fifo16", 32'h8E89BED6, 6'd21, 8'd16, 1'b0);
    check_stream("fifo16_stream");
    check("fifo16_done", done, 1);
    check("fifo16_empty_after", empty, 1);
    check("fifo16_full_after", full, 0);

    // Reset in the middle of the AA field (overall bit 28 = AA bit 20)
    push_byte(8'h02); push_byte(8'h00);
    aa = 32'h8E89BED6; ch_idx = 6'd37; len = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; en = 1'b1;
    repeat (28) @(posedge clk);
    #1 check("mid_tx_valid_before_rst", tx_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_empty", empty, 1);
    rst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    pdu[0] = 8'h02; pdu[1] = 8'h00;
    push_byte(8'h02); push_byte(8'h00);
    build_exp(32'h8E89BED6, 6'd37, 2, 1'b1);
    run_pkt("post_rst", 32'h8E89BED6, 6'd37, 8'd2, 1'b0);
    check_stream("post_rst_stream");
    check("post_rst_done", done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
